// File: rtl/uart_rx_core.sv
// uart_rx_core: 16x-oversampled UART receiver with 3-sample majority vote, parity/framing checks and a receive FIFO.
// Optional macro UART_RX_BREAK_EN: break frames raise status[3] and are not pushed.
module uart_rx_core #(
    parameter int FIFO_DEPTH  = 4,
    parameter int SYNC_STAGES = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] baudrate,
    input  logic [7:0]  control,
    input  logic        rxd,
    input  logic        read_rx,
    output logic        rx_valid,
    output logic [7:0]  rxdata,
    output logic [7:0]  status,
    output logic [2:0]  dbg_state_o
);
    localparam int AW = $clog2(FIFO_DEPTH);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4,
        S_BREAK  = 3'd5
    } state_e;

    logic rx_enable, parity_en, parity_odd, eight_bits, clear_errors;
    logic unused_control;
    assign rx_enable      = control[0];
    assign parity_en      = control[1];
    assign parity_odd     = control[2];
    assign eight_bits     = control[3];
    assign clear_errors   = control[4];
    assign unused_control = ^control[7:5];

    // The divider reloads its compare value only on wrap, so a baudrate change never stalls a count.
    logic [15:0] div_q, baud_q;
    logic        tick;
    assign tick = (div_q == baud_q);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_q  <= '0;
            baud_q <= '0;
        end else if (tick) begin
            div_q  <= '0;
            baud_q <= baudrate;
        end else begin
            div_q <= div_q + 16'd1;
        end
    end

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   rxs;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) sync_q <= '1;
        else        sync_q <= {sync_q[SYNC_STAGES-2:0], rxd};
    end
    assign rxs = sync_q[SYNC_STAGES-1];

    state_e     state_q, state_d;
    logic [3:0] sub_q, sub_d;
    logic [2:0] bit_q, bit_d;
    logic [7:0] shreg_q, shreg_d;
    logic [1:0] samp_q, samp_d;
    logic       par_pend_q, par_pend_d;
    logic       vote, push_req, set_fe, set_pe;
    logic [2:0] last_bit;
`ifdef UART_RX_BREAK_EN
    logic       zero_q, zero_d, set_brk;
`endif

    assign vote     = (samp_q[0] & samp_q[1]) | (samp_q[0] & rxs) | (samp_q[1] & rxs);
    assign last_bit = eight_bits ? 3'd7 : 3'd6;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            sub_q      <= '0;
            bit_q      <= '0;
            shreg_q    <= '0;
            samp_q     <= '0;
            par_pend_q <= 1'b0;
`ifdef UART_RX_BREAK_EN
            zero_q     <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            sub_q      <= sub_d;
            bit_q      <= bit_d;
            shreg_q    <= shreg_d;
            samp_q     <= samp_d;
            par_pend_q <= par_pend_d;
`ifdef UART_RX_BREAK_EN
            zero_q     <= zero_d;
`endif
        end
    end

    always_comb begin
        state_d    = state_q;
        sub_d      = sub_q;
        bit_d      = bit_q;
        shreg_d    = shreg_q;
        samp_d     = samp_q;
        par_pend_d = par_pend_q;
        push_req   = 1'b0;
        set_fe     = 1'b0;
        set_pe     = 1'b0;
`ifdef UART_RX_BREAK_EN
        zero_d     = zero_q;
        set_brk    = 1'b0;
`endif
        if (tick) begin
            if (state_q != S_IDLE) sub_d = sub_q + 4'd1;
            if (sub_q == 4'd7) samp_d[0] = rxs;
            if (sub_q == 4'd8) samp_d[1] = rxs;
            case (state_q)
                S_IDLE: begin
                    if (!rxs && rx_enable) begin
                        state_d    = S_START;
                        sub_d      = '0;
                        shreg_d    = '0;
                        par_pend_d = 1'b0;
`ifdef UART_RX_BREAK_EN
                        zero_d     = 1'b1;
`endif
                    end
                end
                S_START: begin
                    if (sub_q == 4'd9 && vote) begin
                        state_d = S_IDLE;
                    end else if (sub_q == 4'd15) begin
                        state_d = S_DATA;
                        bit_d   = '0;
                    end
                end
                S_DATA: begin
                    // 7-bit frames shift into bit 6 so the first bit lands in bit 0 and bit 7 stays 0.
                    if (sub_q == 4'd9) begin
                        shreg_d = eight_bits ? {vote, shreg_q[7:1]} : {1'b0, vote, shreg_q[6:1]};
`ifdef UART_RX_BREAK_EN
                        if (vote) zero_d = 1'b0;
`endif
                    end
                    if (sub_q == 4'd15) begin
                        if (bit_q == last_bit) state_d = parity_en ? S_PARITY : S_STOP;
                        else                   bit_d   = bit_q + 3'd1;
                    end
                end
                S_PARITY: begin
                    if (sub_q == 4'd9) begin
                        if (vote != (^shreg_q ^ parity_odd)) par_pend_d = 1'b1;
`ifdef UART_RX_BREAK_EN
                        if (vote) zero_d = 1'b0;
`endif
                    end
                    if (sub_q == 4'd15) state_d = S_STOP;
                end
                S_STOP: begin
                    // Leave at mid-stop so a back-to-back start edge is not missed.
                    if (sub_q == 4'd9) begin
                        state_d = S_IDLE;
`ifdef UART_RX_BREAK_EN
                        if (!vote && zero_q) begin
                            set_brk = 1'b1;
                            state_d = S_BREAK;
                            sub_d   = '0;
                        end else begin
                            push_req = 1'b1;
                            set_fe   = !vote;
                            set_pe   = par_pend_q;
                        end
`else
                        push_req = 1'b1;
                        set_fe   = !vote;
                        set_pe   = par_pend_q;
`endif
                    end
                end
`ifdef UART_RX_BREAK_EN
                S_BREAK: begin
                    sub_d = rxs ? sub_q + 4'd1 : 4'd0;
                    if (rxs && sub_q == 4'd15) state_d = S_IDLE;
                end
`endif
                default: state_d = S_IDLE;
            endcase
        end
    end

    logic       push_q;
    logic [7:0] push_data_q;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            push_q      <= 1'b0;
            push_data_q <= '0;
        end else begin
            push_q <= push_req;
            if (push_req) push_data_q <= shreg_q;
        end
    end

    logic [7:0]  mem_q [FIFO_DEPTH];
    logic [AW:0] wr_q, rd_q, count;
    logic        empty, full, pop, wr_en, ovr_set;

    assign count   = wr_q - rd_q;
    assign empty   = (wr_q == rd_q);
    assign full    = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
    assign pop     = read_rx && !empty;
    assign wr_en   = push_q && (!full || pop);
    assign ovr_set = push_q && full && !pop;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_q <= '0;
            rd_q <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
        end else begin
            if (wr_en) begin
                mem_q[wr_q[AW-1:0]] <= push_data_q;
                wr_q                <= wr_q + 1'b1;
            end
            if (pop) rd_q <= rd_q + 1'b1;
        end
    end

    // Sticky flags: a set in the same cycle as clear_errors wins.
    logic ovr_q, fe_q, pe_q, brk_flag;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovr_q <= 1'b0;
            fe_q  <= 1'b0;
            pe_q  <= 1'b0;
        end else begin
            ovr_q <= ovr_set | (ovr_q & ~clear_errors);
            fe_q  <= set_fe  | (fe_q  & ~clear_errors);
            pe_q  <= set_pe  | (pe_q  & ~clear_errors);
        end
    end

`ifdef UART_RX_BREAK_EN
    logic brk_q;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) brk_q <= 1'b0;
        else        brk_q <= set_brk | (brk_q & ~clear_errors);
    end
    assign brk_flag = brk_q;
`else
    assign brk_flag = 1'b0;
`endif

    logic [4:0] count_ext;
    logic [3:0] count_sat;
    assign count_ext = 5'(count);
    assign count_sat = (count_ext > 5'd15) ? 4'hF : count_ext[3:0];

    assign rx_valid    = !empty;
    assign rxdata      = mem_q[rd_q[AW-1:0]];
    assign status      = {count_sat, brk_flag, pe_q, fe_q, ovr_q};
    assign dbg_state_o = state_q;
endmodule

// File: doc/uart_rx_core.md
Name: uart_rx_core

Overview:
Standalone UART receiver: 16x-oversampled, majority-voted, with parity/framing checks and a small receive FIFO. It is the receive end for the uartx2 transmitter and attaches directly to a uartx2 txd line, using the same baudrate/control/read_rx/rx_valid/rxdata conventions. Used as a stand-alone receive peripheral and as a bench-side link checker.

Parameters:
FIFO_DEPTH, 4, receive FIFO entries; power of 2, 2..16.
SYNC_STAGES, 2, rxd synchronizer flops; 2 or 3.

Ports:
clk  input  1  single clock.
rst_n  input  1  asynchronous active-low reset.
baudrate  input  16  oversample divider; one 16x tick every baudrate+1 clk cycles.
control  input  8  [0] rx_enable; [1] parity_en; [2] parity_odd; [3] eight_bits (0 = 7 data bits); [4] clear_errors (level); [7:5] reserved, ignored.
rxd  input  1  serial line, idle high.
read_rx  input  1  pop strobe; ignored when rx_valid=0.
rx_valid  output  1  FIFO non-empty.
rxdata  output  8  FIFO head; 7-bit mode zero-fills bit 7.
status  output  8  [0] overrun, [1] framing_err, [2] parity_err, [3] break (see Optional Feature), [7:4] FIFO count.

Behaviour:
- Reset: rx_valid=0, rxdata=0, status=0, FIFO empty, FSM IDLE, divider=0, synchronizer flops=1.
- Divider: counts 0..baudrate; tick on the cycle it equals baudrate, then wraps to 0. baudrate=0 gives a tick every clk. A baudrate change takes effect at the next wrap.
- rxd passes through SYNC_STAGES flops. rxs is the synchronized value.
- FSM advances only on ticks. sub counts 0..15 within each bit.
- IDLE: on a tick with rxs=0 and rx_enable=1, go to START with sub=0.
- START: at sub=7, 8, 9, sample rxs. At sub=9, if the majority vote is 1 (false start), return to IDLE. Otherwise continue; at sub=15, go to DATA with bit=0.
- DATA: majority vote of samples at sub 7..9. Shift LSB-first into shreg. After 8 bits (or 7), go to PARITY if parity_en, else STOP.
- PARITY: voted bit is compared with XOR(data) ^ parity_odd. A mismatch sets a pending parity flag.
- STOP: voted bit sampled at sub=9. The FSM returns to IDLE at sub=9, not 15, so a back-to-back start edge is caught.
  - Stop bit = 0: set framing_err sticky.
  - In every case, the byte is pushed to the FIFO. If the parity flag is pending, parity_err sticky is set.
- rx_enable dropped mid-frame: the frame completes normally. A new start is not accepted until rx_enable=1.
- FIFO push:
  - Push while full: byte discarded, FIFO contents unchanged, overrun sticky set.
  - Push and pop in the same cycle while full: pop first, push accepted, no overrun.
- Pop: read_rx with rx_valid=1 advances the head; rxdata updates the next cycle. Pop and push in the same cycle on an empty FIFO: the push wins, and read_rx is ignored because rx_valid=0.
- Timing: rx_valid rises the cycle after the push. Push latency is 1 clk after the STOP sub=9 tick.
- Sticky errors clear while clear_errors=1. If a set and a clear occur in the same cycle, the set wins.
- status[7:4] = FIFO count, saturating representation: the full count for depth 16 is reported as 15.
- Pointers are log2(FIFO_DEPTH)+1 bits wide, with wrap detection via the MSB.

Optional Feature:
UART_RX_BREAK_EN
- Defined: a frame with all data bits 0, parity bit (if enabled) 0, and stop 0 sets status[3] sticky instead of framing_err. No byte is pushed. The FSM then waits in a BREAK state until rxs=1 for 16 ticks before returning to IDLE.
- Undefined: status[3] is tied 0. A break frame is treated as a normal framing error with data 0x00 pushed.

Test Plan:
1. Reset/idle: rst_n=0 for 5 clk, rxd=1, baudrate=0, control=0x09 -> rx_valid=0, status=0x00, rxdata=0x00 throughout 500 clk.
2. Basic byte: baudrate=0, control=0x09; drive 0xA5 with 16 clk/bit, 8N1 -> rx_valid=1 within 1 clk of the stop mid-sample, rxdata=0xA5, status=0x10. read_rx pulse -> rx_valid=0, status=0x00.
3. Parity:
   - control=0x0F (odd parity); send 0x3C with parity bit 1 -> rxdata=0x3C, status[2]=0.
   - Resend 0x3C with parity bit 0 -> status[2]=1.
   - control=0x1F for 1 clk -> status[2]=0.
4. Overrun: FIFO_DEPTH=4, send 0x01..0x05 with no reads -> status[0]=1, count=4. Reads return 0x01, 0x02, 0x03, 0x04; 0x05 is lost.
5. Glitch/false start: baudrate=3, rxd low for 20 clk (5 ticks) then high -> no push, FSM back in IDLE. The next valid frame 0x55 is received correctly.
6. Framing/break: send 0x00 with stop=0.
   - With UART_RX_BREAK_EN: status[3]=1, no push, FSM in BREAK until 16 high ticks.
   - Without: status[1]=1, rxdata=0x00.
